// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, round helper functions and core state type
package sha256_pkg;

   typedef enum logic [2:0] {
      LOAD,
      PAD,
      ROUNDS,
      UPDATE,
      DONE
   } state_t;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] H_INIT [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // Rotations are written as fixed concatenations so every shift is constant.
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
   import sha256_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   input  logic [31:0] e,
   input  logic [31:0] f,
   input  logic [31:0] g,
   input  logic [31:0] h,
   input  logic [31:0] wt,
   input  logic [31:0] kt,
   output logic [31:0] a_next,
   output logic [31:0] b_next,
   output logic [31:0] c_next,
   output logic [31:0] d_next,
   output logic [31:0] e_next,
   output logic [31:0] f_next,
   output logic [31:0] g_next,
   output logic [31:0] h_next
);

   logic [31:0] t1;
   logic [31:0] t2;

   // Two temporaries feed the new a and e; the rest of the state just slides down.
   always_comb begin
      t1     = h + bsig1(e) + ch(e, f, g) + kt + wt;
      t2     = bsig0(a) + maj(a, b, c);
      a_next = t1 + t2;
      b_next = a;
      c_next = b;
      d_next = c;
      e_next = d + t1;
      f_next = e;
      g_next = f;
      h_next = g;
   end

endmodule

// File: rtl/sha256_core.sv
// rtl/sha256_core.sv - streaming SHA-256 hasher with in-core padding and schedule window
module sha256_core
   import sha256_pkg::*;
(
   input  logic [31:0]  input_data,
   input  logic         input_valid,
   output logic         input_ready,
   input  logic         last_word,
   input  logic         clk,
   input  logic         rst,
   output logic         output_valid,
   output logic [255:0] hash_data
);

   state_t      state;
   logic [31:0] w    [0:15];   // message block, later the sliding schedule window
   logic [31:0] hv   [0:7];    // chaining value H0..H7
   logic [31:0] wv   [0:7];    // working variables a..h
   logic [31:0] hsum [0:7];
   logic [4:0]  idx;           // next W slot to fill; 16 means the block is full
   logic [5:0]  rnd;
   logic [63:0] bitlen;
   logic        one_done;      // the 0x80000000 marker has been written
   logic        len_fits;      // the length words go into the current block
   logic        pad_pending;   // another padding block follows this compression
   logic        final_blk;     // this compression produces the digest
   logic [31:0] w_new;
   logic [31:0] rn_a, rn_b, rn_c, rn_d, rn_e, rn_f, rn_g, rn_h;

   // W[t+16] from the window holding W[t..t+15]; extra words past round 47 are never used.
   assign w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

   sha256_round u_round (
      .a      (wv[0]),
      .b      (wv[1]),
      .c      (wv[2]),
      .d      (wv[3]),
      .e      (wv[4]),
      .f      (wv[5]),
      .g      (wv[6]),
      .h      (wv[7]),
      .wt     (w[0]),
      .kt     (K[rnd]),
      .a_next (rn_a),
      .b_next (rn_b),
      .c_next (rn_c),
      .d_next (rn_d),
      .e_next (rn_e),
      .f_next (rn_f),
      .g_next (rn_g),
      .h_next (rn_h)
   );

   // Chaining value plus working variables, committed at the end of every block
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         hsum[i] = hv[i] + wv[i];
      end
   end

   // Control FSM, message/schedule storage, counters and the chaining value
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD;
         idx          <= '0;
         rnd          <= '0;
         bitlen       <= '0;
         one_done     <= 1'b0;
         len_fits     <= 1'b0;
         pad_pending  <= 1'b0;
         final_blk    <= 1'b0;
         input_ready  <= 1'b1;
         output_valid <= 1'b0;
         hash_data    <= '0;
         for (int i = 0; i < 8; i++) begin
            hv[i] <= H_INIT[i];
            wv[i] <= H_INIT[i];
         end
         for (int i = 0; i < 16; i++) begin
            w[i] <= '0;
         end
      end else begin
         case (state)
            LOAD: begin
               if (input_valid && input_ready) begin
                  w[idx[3:0]] <= input_data;
                  idx         <= idx + 5'd1;
                  bitlen      <= bitlen + 64'd32;
                  if (last_word) begin
                     state       <= PAD;
                     input_ready <= 1'b0;
                  end else if (idx == 5'd15) begin
                     state       <= ROUNDS;
                     input_ready <= 1'b0;
                  end
               end
            end
            PAD: begin
               if (idx == 5'd16) begin
                  // Block filled before the length could be placed: compress and come back.
                  pad_pending <= 1'b1;
                  state       <= ROUNDS;
               end else begin
                  idx <= idx + 5'd1;
                  if (!one_done) begin
                     w[idx[3:0]] <= 32'h8000_0000;
                     one_done    <= 1'b1;
                     len_fits    <= (idx <= 5'd13);
                  end else if (len_fits && idx == 5'd14) begin
                     w[14] <= bitlen[63:32];
                  end else if (len_fits && idx == 5'd15) begin
                     w[15]     <= bitlen[31:0];
                     final_blk <= 1'b1;
                     state     <= ROUNDS;
                  end else begin
                     w[idx[3:0]] <= '0;
                  end
               end
            end
            ROUNDS: begin
               wv[0] <= rn_a;
               wv[1] <= rn_b;
               wv[2] <= rn_c;
               wv[3] <= rn_d;
               wv[4] <= rn_e;
               wv[5] <= rn_f;
               wv[6] <= rn_g;
               wv[7] <= rn_h;
               for (int i = 0; i < 15; i++) begin
                  w[i] <= w[i+1];
               end
               w[15] <= w_new;
               rnd   <= rnd + 6'd1;
               if (rnd == 6'd63) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               // Working variables restart from the new chaining value for the next block.
               for (int i = 0; i < 8; i++) begin
                  hv[i] <= hsum[i];
                  wv[i] <= hsum[i];
               end
               idx <= '0;
               if (pad_pending) begin
                  pad_pending <= 1'b0;
                  len_fits    <= 1'b1;
                  state       <= PAD;
               end else if (final_blk) begin
                  hash_data    <= {hsum[0], hsum[1], hsum[2], hsum[3],
                                   hsum[4], hsum[5], hsum[6], hsum[7]};
                  output_valid <= 1'b1;
                  state        <= DONE;
               end else begin
                  input_ready <= 1'b1;
                  state       <= LOAD;
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_core.sv
// tb/tb_sha256_core.sv - scoreboard bench for the streaming SHA-256 core
module tb_sha256_core;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  input_data = '0;
   logic         input_valid = 1'b0;
   logic         input_ready;
   logic         last_word = 1'b0;
   logic         output_valid;
   logic [255:0] hash_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [255:0] exp_q [$];

   localparam logic [255:0] ABCD_HASH = 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;
   localparam logic [255:0] ABC448_HASH = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [31:0] TK [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] TH [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   always #5 clk = ~clk;

   sha256_core dut (
      .input_data   (input_data),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .last_word    (last_word),
      .clk          (clk),
      .rst          (rst),
      .output_valid (output_valid),
      .hash_data    (hash_data)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_model(input logic [31:0] msg [$]);
      logic [31:0] blk [$];
      logic [31:0] hh [0:7];
      logic [31:0] ws [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      logic [63:0] nbits;
      blk   = msg;
      nbits = 64'(msg.size()) * 64'd32;
      blk.push_back(32'h8000_0000);
      while ((blk.size() % 16) != 14) blk.push_back(32'h0);
      blk.push_back(nbits[63:32]);
      blk.push_back(nbits[31:0]);
      for (int i = 0; i < 8; i++) hh[i] = TH[i];
      for (int n = 0; n < blk.size() / 16; n++) begin
         for (int t = 0; t < 64; t++) begin
            if (t < 16) ws[t] = blk[n*16 + t];
            else ws[t] = (rr(ws[t-2], 17) ^ rr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
                       + (rr(ws[t-15], 7) ^ rr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
         end
         a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
         e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
         for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + TK[t] + ws[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
         end
         hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
         hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
      end
      return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
   endfunction

   // Called at a negedge; leaves the core just out of reset at a negedge.
   task automatic do_reset();
      rst         = 1'b1;
      input_valid = 1'b0;
      last_word   = 1'b0;
      input_data  = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_msg(input logic [31:0] m [$], input bit toggle, input bit mark_last, output int wait16);
      int waits;
      wait16 = -1;
      for (int i = 0; i < m.size(); i++) begin
         input_data  = m[i];
         input_valid = 1'b1;
         last_word   = mark_last && (i == m.size() - 1);
         waits = 0;
         while (!input_ready && waits < 200) begin
            @(negedge clk);
            waits++;
         end
         if (i == 16) wait16 = waits;
         if (!input_ready) begin
            check("send_ready_timeout", 256'(input_ready), 256'd1);
            break;
         end
         @(negedge clk);
         if (toggle) begin
            input_valid = 1'b0;
            input_data  = $urandom;
            last_word   = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
      end
      input_valid = 1'b0;
      last_word   = 1'b0;
   endtask

   task automatic wait_digest(input string tag);
      int cyc;
      logic [255:0] exp;
      cyc = 0;
      while (!output_valid && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      if (exp_q.size() == 0) begin
         check({tag, "_no_expected"}, 256'd0, 256'd1);
         return;
      end
      exp = exp_q.pop_front();
      if (!output_valid) check({tag, "_timeout"}, 256'(output_valid), 256'd1);
      else check(tag, hash_data, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] m [$];
      logic [31:0] m24 [$];
      int w16;

      @(negedge clk);
      do_reset();
      check("reset_output_valid", 256'(output_valid), 256'd0);
      check("reset_input_ready", 256'(input_ready), 256'd1);
      check("reset_hash_data", hash_data, 256'd0);

      // Single-word message
      m = '{32'h61626364};
      exp_q.push_back(ABCD_HASH);
      send_msg(m, 1'b0, 1'b1, w16);
      check("abcd_ready_after_last", 256'(input_ready), 256'd0);
      wait_digest("abcd_digest");
      repeat (5) @(negedge clk);
      check("abcd_valid_sticky", 256'(output_valid), 256'd1);

      // Words offered after the digest must be ignored
      for (int i = 0; i < 6; i++) begin
         input_data  = $urandom;
         input_valid = 1'b1;
         last_word   = i[0];
         @(negedge clk);
      end
      input_valid = 1'b0;
      last_word   = 1'b0;
      check("done_hash_hold", hash_data, ABCD_HASH);
      check("done_ready_low", 256'(input_ready), 256'd0);
      check("done_valid_hold", 256'(output_valid), 256'd1);

      // 14-word message, padding spills into a second block
      do_reset();
      m.delete();
      for (int i = 0; i < 14; i++) begin
         m.push_back({8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)});
      end
      exp_q.push_back(ABC448_HASH);
      send_msg(m, 1'b0, 1'b1, w16);
      wait_digest("abc448_digest");

      // Exactly one full block, padding is a block of its own
      do_reset();
      m.delete();
      for (int i = 0; i < 16; i++) m.push_back($urandom);
      exp_q.push_back(sha_model(m));
      send_msg(m, 1'b0, 1'b1, w16);
      wait_digest("w16_digest");

      // 24 words back to back; input_ready is low while the first block compresses
      do_reset();
      m24.delete();
      for (int i = 0; i < 24; i++) m24.push_back($urandom);
      exp_q.push_back(sha_model(m24));
      send_msg(m24, 1'b0, 1'b1, w16);
      check("w24_ready_gap", 256'(w16), 256'd65);
      wait_digest("w24_b2b_digest");

      // Same 24 words with input_valid toggling every cycle
      do_reset();
      exp_q.push_back(sha_model(m24));
      send_msg(m24, 1'b1, 1'b1, w16);
      wait_digest("w24_toggle_digest");

      // Abort during ROUNDS, then a fresh message
      do_reset();
      m.delete();
      for (int i = 0; i < 16; i++) m.push_back($urandom);
      send_msg(m, 1'b0, 1'b0, w16);
      repeat (10) @(negedge clk);
      do_reset();
      check("abort_output_valid", 256'(output_valid), 256'd0);
      check("abort_input_ready", 256'(input_ready), 256'd1);
      check("abort_hash_data", hash_data, 256'd0);
      m = '{32'h61626364};
      exp_q.push_back(ABCD_HASH);
      send_msg(m, 1'b0, 1'b1, w16);
      wait_digest("abort_abcd_digest");

      check("scoreboard_drained", 256'(exp_q.size()), 256'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
